// File: rtl/sr_fetch.sv
// sr_fetch: instruction fetch stage in front of the single-cycle decode/execute core.
//
// Owns the program counter and issues word-addressed requests to a variable-latency,
// in-order instruction memory. Each accepted request's PC is held in an in-flight FIFO
// so that the response can be tagged with it. Tagged responses land in a small queue that
// decode drains over a valid/ready handshake. A redirect restarts fetch at a new PC,
// flushes the queue and marks every in-flight request as to-be-discarded.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   redirect_valid  restart fetch at redirect_pc (priority over all other activity)
//   redirect_pc     byte address of the new fetch target (bits [1:0] ignored)
//   mem_req_*       request channel: valid/ready handshake, word address
//   mem_rsp_*       response channel: in request order, no backpressure
//   instr_*         queue head to decode: valid/ready, instruction word and its byte PC
module sr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;

  // Instruction queue
  logic [31:0]     q_pc_q    [DEPTH];
  logic [31:0]     q_instr_q [DEPTH];
  logic [PtrW-1:0] q_rd_q, q_rd_d;
  logic [PtrW-1:0] q_wr_q, q_wr_d;
  logic [CntW-1:0] q_cnt_q, q_cnt_d;

  // In-flight PC FIFO: one entry per accepted, not yet answered request
  logic [31:0]     if_pc_q [DEPTH];
  logic [PtrW-1:0] if_rd_q, if_rd_d;
  logic [PtrW-1:0] if_wr_q, if_wr_d;

  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] disc_q, disc_d;

  logic [CntW:0]   credit_sum;
  logic            req_fire;
  logic            rsp_fire;
  logic            deq_fire;
  logic            push;

  // Credits cover both queued and in-flight entries, so a response always has a slot.
  assign credit_sum    = {1'b0, out_q} + {1'b0, q_cnt_q};
  assign mem_req_valid = ~rst & ~redirect_valid & (credit_sum < DepthW);
  assign mem_req_addr  = rst ? (ResetPcAligned >> 2) : (fetch_pc_q >> 2);

  assign instr_valid   = ~rst & (q_cnt_q != '0);
  assign instr         = instr_valid ? q_instr_q[q_rd_q] : 32'h0;
  assign instr_pc      = instr_valid ? q_pc_q[q_rd_q]    : 32'h0;

  assign req_fire = mem_req_valid & mem_req_ready;
  assign rsp_fire = mem_rsp_valid & ~rst;
  assign deq_fire = instr_valid & instr_ready & ~redirect_valid;
  // A response is kept only outside a redirect cycle and once all stale ones are gone.
  assign push     = rsp_fire & ~redirect_valid & (disc_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    q_cnt_d    = q_cnt_q;
    if_rd_d    = if_rd_q;
    if_wr_d    = if_wr_q;
    out_d      = out_q + CntW'(req_fire) - CntW'(rsp_fire);
    disc_d     = disc_q;

    if (req_fire) begin
      if_wr_d = if_wr_q + PtrW'(1);
    end
    if (rsp_fire) begin
      if_rd_d = if_rd_q + PtrW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      q_rd_d     = q_wr_q;
      q_cnt_d    = '0;
      // Everything still in flight after this cycle's response belongs to the old path.
      disc_d     = out_q - CntW'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_fire && (disc_q != '0)) begin
        disc_d = disc_q - CntW'(1);
      end
      if (push) begin
        q_wr_d = q_wr_q + PtrW'(1);
      end
      if (deq_fire) begin
        q_rd_d = q_rd_q + PtrW'(1);
      end
      q_cnt_d = q_cnt_q + CntW'(push) - CntW'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= ResetPcAligned;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      q_cnt_q    <= '0;
      if_rd_q    <= '0;
      if_wr_q    <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      q_cnt_q    <= q_cnt_d;
      if_rd_q    <= if_rd_d;
      if_wr_q    <= if_wr_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      if_pc_q[if_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_pc_q[q_wr_q]    <= if_pc_q[if_rd_q];
      q_instr_q[q_wr_q] <= mem_rsp_data;
    end
  end

endmodule
